// File: rtl/tpu_isa_pkg.sv
// rtl/tpu_isa_pkg.sv - TPU instruction set constants, width helper and operand descriptor type.
package tpu_isa_pkg;

  localparam int DEF_OP_W   = 3;
  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DIM_W  = 8;

  localparam int OP_NOP    = 0;
  localparam int OP_LOAD   = 1;
  localparam int OP_STORE  = 2;
  localparam int OP_MATMUL = 3;
  localparam int OP_CONV   = 4;

  function automatic int instr_width(input int op_w, input int addr_w, input int dim_w);
    return op_w + 3 * (addr_w + 3 * dim_w);
  endfunction

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DIM_W-1:0]  ch;
    logic [DEF_DIM_W-1:0]  row;
    logic [DEF_DIM_W-1:0]  col;
  } operand_t;

endpackage

// File: rtl/instr_decode_queue_if.sv
// rtl/instr_decode_queue_if.sv - instruction push port and decoded-instruction port of the decode queue.
interface instr_decode_queue_if
  import tpu_isa_pkg::*;
#(
  parameter int OP_W   = DEF_OP_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DIM_W  = DEF_DIM_W,
  parameter int DEPTH  = 4
);

  localparam int INSTR_W = instr_width(OP_W, ADDR_W, DIM_W);
  localparam int CNT_W   = $clog2(DEPTH + 1);

  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr;
  logic               dec_valid;
  logic               dec_ready;
  logic [OP_W-1:0]    op;
  logic [ADDR_W-1:0]  wb_addr, a_addr, b_addr;
  logic [DIM_W-1:0]   wb_ch, wb_row, wb_col;
  logic [DIM_W-1:0]   a_ch, a_row, a_col;
  logic [DIM_W-1:0]   b_ch, b_row, b_col;
  logic               dec_illegal;
  logic               err_sticky;
  logic [CNT_W-1:0]   q_count;

  modport master (
    output instr_valid, instr, dec_ready,
    input  instr_ready, dec_valid, op,
    input  wb_addr, wb_ch, wb_row, wb_col,
    input  a_addr, a_ch, a_row, a_col,
    input  b_addr, b_ch, b_row, b_col,
    input  dec_illegal, err_sticky, q_count
  );

  modport slave (
    input  instr_valid, instr, dec_ready,
    output instr_ready, dec_valid, op,
    output wb_addr, wb_ch, wb_row, wb_col,
    output a_addr, a_ch, a_row, a_col,
    output b_addr, b_ch, b_row, b_col,
    output dec_illegal, err_sticky, q_count
  );

endinterface

// File: rtl/instr_decode_queue_fifo.sv
// rtl/instr_decode_queue_fifo.sv - instr_fifo: power-of-two circular buffer with occupancy count.
module instr_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage is not reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/instr_decode_queue.sv
// rtl/instr_decode_queue.sv - queued TPU instruction decoder with registered output and sticky error.
// Define DECODE_NOP_DROP_EN to discard NOPs at the queue head instead of presenting them.
module instr_decode_queue
  import tpu_isa_pkg::*;
#(
  parameter int OP_W   = DEF_OP_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DIM_W  = DEF_DIM_W,
  parameter int DEPTH  = 4
) (
  input logic                 clk,
  input logic                 rst,
  instr_decode_queue_if.slave bus
);

  localparam int INSTR_W = instr_width(OP_W, ADDR_W, DIM_W);
  localparam int OPND_W  = ADDR_W + 3 * DIM_W;
  localparam int CNT_W   = $clog2(DEPTH + 1);

  logic [INSTR_W-1:0] head, src, dec_q;
  logic [OP_W-1:0]    src_op;
  logic               fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [CNT_W-1:0]   fifo_count;
  logic               push_fire, load_en, src_valid, src_drop, src_take;
  logic               dec_valid_q, err_q;
  logic [OPND_W-1:0]  wb_d, a_d, b_d;

  instr_fifo #(.WIDTH(INSTR_W), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (bus.instr),
    .pop       (fifo_pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign push_fire = bus.instr_valid && !fifo_full;
  assign load_en   = !dec_valid_q || bus.dec_ready;

  // An empty queue lets the incoming instruction go straight to the output stage.
  assign src       = fifo_empty ? bus.instr : head;
  assign src_valid = fifo_empty ? push_fire : 1'b1;
  assign src_op    = src[INSTR_W-1 -: OP_W];

`ifdef DECODE_NOP_DROP_EN
  assign src_drop = (src_op == OP_W'(OP_NOP));
`else
  assign src_drop = 1'b0;
`endif

  // A dropped NOP is consumed even while the output is stalled.
  assign src_take  = src_valid && (load_en || src_drop);
  assign fifo_pop  = !fifo_empty && src_take;
  assign fifo_push = push_fire && !(fifo_empty && src_take);

  always_ff @(posedge clk) begin
    if (rst) begin
      dec_valid_q <= 1'b0;
      dec_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      if (dec_valid_q && bus.dec_ready && bus.dec_illegal) err_q <= 1'b1;
      if (load_en) dec_valid_q <= src_valid && !src_drop;
      if (load_en && src_valid && !src_drop) dec_q <= src;
    end
  end

  assign wb_d = dec_q[2*OPND_W +: OPND_W];
  assign a_d  = dec_q[OPND_W +: OPND_W];
  assign b_d  = dec_q[0 +: OPND_W];

  assign bus.instr_ready = !fifo_full;
  assign bus.dec_valid   = dec_valid_q;
  assign bus.op          = dec_q[INSTR_W-1 -: OP_W];
  assign bus.dec_illegal = dec_valid_q && (bus.op > OP_W'(OP_CONV));
  assign bus.err_sticky  = err_q;
  assign bus.q_count     = fifo_count;

  assign bus.wb_addr = wb_d[OPND_W-1 -: ADDR_W];
  assign bus.wb_ch   = wb_d[3*DIM_W-1 -: DIM_W];
  assign bus.wb_row  = wb_d[2*DIM_W-1 -: DIM_W];
  assign bus.wb_col  = wb_d[DIM_W-1:0];
  assign bus.a_addr  = a_d[OPND_W-1 -: ADDR_W];
  assign bus.a_ch    = a_d[3*DIM_W-1 -: DIM_W];
  assign bus.a_row   = a_d[2*DIM_W-1 -: DIM_W];
  assign bus.a_col   = a_d[DIM_W-1:0];
  assign bus.b_addr  = b_d[OPND_W-1 -: ADDR_W];
  assign bus.b_ch    = b_d[3*DIM_W-1 -: DIM_W];
  assign bus.b_row   = b_d[2*DIM_W-1 -: DIM_W];
  assign bus.b_col   = b_d[DIM_W-1:0];

endmodule
